// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the 2x2 pooling window generator.
package pool_pkg;

    localparam int POOL_DATA_WIDTH = 32;
    localparam int POOL_IMG_W      = 224;
    localparam int POOL_IMG_H      = 224;

    // Counter width for a range 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [POOL_DATA_WIDTH-1:0] a;
        logic [POOL_DATA_WIDTH-1:0] b;
        logic [POOL_DATA_WIDTH-1:0] c;
        logic [POOL_DATA_WIDTH-1:0] d;
    } pool_win_t;

endpackage

// File: rtl/pool_line_buf.sv
// One-row pixel store: single write port, combinational reads at addr-1 and addr.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = POOL_DATA_WIDTH,
    parameter int DEPTH      = POOL_IMG_W,
    parameter int ADDR_W     = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rd_prev,
    output logic [DATA_WIDTH-1:0] rd_cur
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     prev_addr;

    assign prev_addr = addr - ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rd_prev = mem[prev_addr];
    assign rd_cur  = mem[addr];

endmodule

// File: rtl/pool_window_gen.sv
// Raster pixel stream to non-overlapping stride-2 2x2 windows for the max-pool tree.
// Define POOL_WIN_FRAME_DONE_EN to add the frame_done last-window pulse.
module pool_window_gen
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = POOL_DATA_WIDTH,
    parameter int IMG_W      = POOL_IMG_W,
    parameter int IMG_H      = POOL_IMG_H
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] win_a,
    output logic [DATA_WIDTH-1:0] win_b,
    output logic [DATA_WIDTH-1:0] win_c,
    output logic [DATA_WIDTH-1:0] win_d
`ifdef POOL_WIN_FRAME_DONE_EN
    ,
    output logic                  frame_done
`endif
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam int LAST_COL = 2 * (IMG_W / 2) - 1;
    localparam int LAST_ROW = 2 * (IMG_H / 2) - 1;

    logic [CW-1:0]         col_cnt;
    logic [RW-1:0]         row_cnt;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] buf_prev;
    logic [DATA_WIDTH-1:0] buf_cur;
    logic                  take;
    logic                  emit;
    logic                  col_last;
    logic                  row_last;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] win_a_p1;
    logic [DATA_WIDTH-1:0] win_b_p1;
    logic [DATA_WIDTH-1:0] win_c_p1;
    logic [DATA_WIDTH-1:0] win_d_p1;

    // clr outranks valid_in, so a pixel arriving with clr is never accepted.
    assign take     = valid_in && !clr;
    assign emit     = take && row_cnt[0] && col_cnt[0];
    assign col_last = (col_cnt == CW'(IMG_W - 1));
    assign row_last = (row_cnt == RW'(IMG_H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (clr) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (take && row_cnt[0] && !col_cnt[0]) begin
            hold <= data_in;
        end
    end

    pool_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_W),
        .ADDR_W     (CW)
    ) u_line_buf (
        .clk     (clk),
        .we      (take && !row_cnt[0]),
        .addr    (col_cnt),
        .wdata   (data_in),
        .rd_prev (buf_prev),
        .rd_cur  (buf_cur)
    );

    // Stage p1: window output registers, held between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            win_a_p1 <= '0;
            win_b_p1 <= '0;
            win_c_p1 <= '0;
            win_d_p1 <= '0;
        end else begin
            vld_p1 <= emit;
            if (emit) begin
                win_a_p1 <= buf_prev;
                win_b_p1 <= buf_cur;
                win_c_p1 <= hold;
                win_d_p1 <= data_in;
            end
        end
    end

    assign valid_out = vld_p1;
    assign win_a     = win_a_p1;
    assign win_b     = win_b_p1;
    assign win_c     = win_c_p1;
    assign win_d     = win_d_p1;

`ifdef POOL_WIN_FRAME_DONE_EN
    logic done_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_p1 <= 1'b0;
        end else begin
            done_p1 <= emit && (row_cnt == RW'(LAST_ROW)) && (col_cnt == CW'(LAST_COL));
        end
    end

    assign frame_done = done_p1;
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// Randomized bench for pool_window_gen: a 4x4 and a 5x5 instance against an image-array model.
module tb_pool_window_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        valid_i [2];
    logic [31:0] data_i  [2];
    logic        vo      [2];
    logic [31:0] wa [2], wb [2], wc [2], wd [2];
`ifdef POOL_WIN_FRAME_DONE_EN
    logic        fd [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: each frame kept as a plain 2D image.
    int          idx   [2];
    logic [31:0] img   [2][5][5];
    logic        e_vld [2];
    logic        e_fd  [2];
    logic [31:0] e_a [2], e_b [2], e_c [2], e_d [2];
    logic        prev_vo [2];
    int          n_str [2];
    int          n_fd  [2];

    always #5 clk = ~clk;

    pool_window_gen #(.DATA_WIDTH(32), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr),
        .valid_in(valid_i[0]), .data_in(data_i[0]), .valid_out(vo[0]),
        .win_a(wa[0]), .win_b(wb[0]), .win_c(wc[0]), .win_d(wd[0])
`ifdef POOL_WIN_FRAME_DONE_EN
        , .frame_done(fd[0])
`endif
    );

    pool_window_gen #(.DATA_WIDTH(32), .IMG_W(5), .IMG_H(5)) dut5 (
        .clk(clk), .rst(rst), .clr(clr),
        .valid_in(valid_i[1]), .data_in(data_i[1]), .valid_out(vo[1]),
        .win_a(wa[1]), .win_b(wb[1]), .win_c(wc[1]), .win_d(wd[1])
`ifdef POOL_WIN_FRAME_DONE_EN
        , .frame_done(fd[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input int k, input logic v, input logic [31:0] d, input logic c);
        int w, r, cc;
        w = (k == 0) ? 4 : 5;
        e_vld[k] = 1'b0;
        e_fd[k]  = 1'b0;
        if (c) begin
            idx[k] = 0;
        end else if (v) begin
            r  = idx[k] / w;
            cc = idx[k] % w;
            img[k][r][cc] = d;
            if (r % 2 == 1 && cc % 2 == 1) begin
                e_vld[k] = 1'b1;
                e_a[k] = img[k][r-1][cc-1];
                e_b[k] = img[k][r-1][cc];
                e_c[k] = img[k][r][cc-1];
                e_d[k] = d;
                e_fd[k] = (r == 2 * (w / 2) - 1) && (cc == 2 * (w / 2) - 1);
            end
            idx[k] = (idx[k] + 1) % (w * w);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("valid_out%0d", k), 32'(vo[k]), 32'(e_vld[k]));
            chk($sformatf("back_to_back%0d", k), 32'(vo[k] & prev_vo[k]), 32'd0);
            chk($sformatf("win_a%0d", k), wa[k], e_a[k]);
            chk($sformatf("win_b%0d", k), wb[k], e_b[k]);
            chk($sformatf("win_c%0d", k), wc[k], e_c[k]);
            chk($sformatf("win_d%0d", k), wd[k], e_d[k]);
`ifdef POOL_WIN_FRAME_DONE_EN
            chk($sformatf("frame_done%0d", k), 32'(fd[k]), 32'(e_fd[k]));
            if (fd[k] === 1'b1) n_fd[k]++;
`endif
            if (vo[k] === 1'b1) n_str[k]++;
            prev_vo[k] = vo[k];
        end
    endtask

    task automatic step(input int k, input logic v, input logic [31:0] d, input logic c);
        for (int j = 0; j < 2; j++) begin
            valid_i[j] = (j == k) ? v : 1'b0;
            data_i[j]  = (j == k) ? d : 32'hDEAD_BEEF;
            model_step(j, valid_i[j], data_i[j], c);
        end
        clr = c;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b0;
        for (int j = 0; j < 2; j++) valid_i[j] = 1'b0;
        #1;
        for (int n = 0; n < 2; n++) begin
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("rst_valid%0d", j), 32'(vo[j]), 32'd0);
                chk($sformatf("rst_win_a%0d", j), wa[j], 32'd0);
                chk($sformatf("rst_win_b%0d", j), wb[j], 32'd0);
                chk($sformatf("rst_win_c%0d", j), wc[j], 32'd0);
                chk($sformatf("rst_win_d%0d", j), wd[j], 32'd0);
`ifdef POOL_WIN_FRAME_DONE_EN
                chk($sformatf("rst_frame_done%0d", j), 32'(fd[j]), 32'd0);
`endif
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        for (int j = 0; j < 2; j++) begin
            idx[j] = 0;
            e_vld[j] = 1'b0; e_fd[j] = 1'b0; prev_vo[j] = 1'b0;
            e_a[j] = '0; e_b[j] = '0; e_c[j] = '0; e_d[j] = '0;
        end
    endtask

    // Sends n pixels (base, base+1, ... or random) with 0..gap_max idle cycles before each.
    task automatic send(input int k, input int base, input int n, input int gap_max, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < gap; g++) step(k, 1'b0, 32'd0, 1'b0);
            step(k, 1'b1, rnd ? $urandom : 32'(base + i), 1'b0);
        end
    endtask

    initial begin
        int s0, f0;
        for (int j = 0; j < 2; j++) begin
            valid_i[j] = 1'b0; data_i[j] = '0; n_str[j] = 0; n_fd[j] = 0; prev_vo[j] = 1'b0;
        end
        do_reset();

        s0 = n_str[0];
        send(0, 1, 16, 0, 0);
        step(0, 1'b0, 0, 1'b0);
        chk("strobes_4x4", 32'(n_str[0] - s0), 32'd4);

        s0 = n_str[1];
        send(1, 1, 25, 0, 0);
        step(1, 1'b0, 0, 1'b0);
        chk("strobes_5x5", 32'(n_str[1] - s0), 32'd4);

        s0 = n_str[0];
        send(0, 1, 16, 5, 0);
        chk("strobes_gaps", 32'(n_str[0] - s0), 32'd4);

        s0 = n_str[0];
        f0 = n_fd[0];
        send(0, 1, 16, 0, 0);
        send(0, 101, 16, 0, 0);
        step(0, 1'b0, 0, 1'b0);
        chk("strobes_b2b", 32'(n_str[0] - s0), 32'd8);
`ifdef POOL_WIN_FRAME_DONE_EN
        chk("frame_done_b2b", 32'(n_fd[0] - f0), 32'd2);
`endif

        send(0, 1, 7, 0, 0);
        step(0, 1'b1, 32'd99, 1'b1);
        s0 = n_str[0];
        send(0, 1, 16, 0, 0);
        step(0, 1'b0, 0, 1'b0);
        chk("strobes_after_clr", 32'(n_str[0] - s0), 32'd4);

        send(0, 1, 10, 0, 0);
        do_reset();
        s0 = n_str[0];
        send(0, 1, 16, 0, 0);
        step(0, 1'b0, 0, 1'b0);
        chk("strobes_after_rst", 32'(n_str[0] - s0), 32'd4);

        for (int t = 0; t < 12; t++) begin
            int k;
            k = t % 2;
            s0 = n_str[k];
            send(k, 0, (k == 0) ? 16 : 25, 2, 1);
            step(k, 1'b0, 0, 1'b0);
            chk($sformatf("strobes_rand%0d", k), 32'(n_str[k] - s0), 32'd4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
